// File: rtl/fpga_console_pkg.sv
// Shared types and tx_word field positions for the host-to-firmware console channel.
package fpga_console_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StHoldoff
  } console_state_e;

  localparam int unsigned CHAR_LSB  = 0;
  localparam int unsigned LEVEL_LSB = 8;
  localparam int unsigned OVF_BIT   = 30;
  localparam int unsigned SEQ_BIT   = 31;

endpackage

// File: rtl/console_sync_fifo.sv
// Single-clock show-ahead FIFO with flopped storage and synchronous flush.
module console_sync_fifo #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1,
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               push,
  input  logic [DATA_W-1:0]  din,
  input  logic               pop,
  input  logic               flush,
  output logic [DATA_W-1:0]  dout,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0] level_q;
  logic               push_ok, pop_ok;

  assign full  = (level_q == LEVEL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop on the same edge frees the slot, so a push at full is still taken.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok) begin
        level_q <= level_q + LEVEL_W'(1);
      end else if (pop_ok && !push_ok) begin
        level_q <= level_q - LEVEL_W'(1);
      end
    end
  end

endmodule

// File: rtl/fpga_console_tx.sv
// Host-to-firmware console: buffers host bytes and presents them with a toggle handshake.
// Optional pacing between presentations is enabled by defining CONSOLE_TX_PACE_EN.
module fpga_console_tx
  import fpga_console_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               core_clk,
  input  logic               rst_b,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               flush,
  input  logic               fw_ack_seq,
  input  logic [15:0]        pace_div,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               overflow,
  output logic [31:0]        tx_word,
  output logic               tx_pending
);

  console_state_e    state_q, state_d;
  logic              seq_q, seq_d;
  logic [DATA_W-1:0] char_q, char_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] fifo_dout;
  logic              pop;
  logic [7:0]        level_sat;

`ifdef CONSOLE_TX_PACE_EN
  logic [15:0] cnt_q, cnt_d;
`else
  logic unused_pace;
  assign unused_pace = ^pace_div;
`endif

  // No pop during flush: the FIFO contents are being discarded on that edge.
  assign pop = (state_q == StIdle) && !fifo_empty && !flush;

  console_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (core_clk),
    .rst_b (rst_b),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (pop),
    .flush (flush),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    char_d  = char_q;
`ifdef CONSOLE_TX_PACE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (pop) begin
          char_d  = fifo_dout;
          seq_d   = ~seq_q;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (fw_ack_seq == seq_q) begin
`ifdef CONSOLE_TX_PACE_EN
          state_d = StHoldoff;
          cnt_d   = pace_div;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef CONSOLE_TX_PACE_EN
      StHoldoff: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 16'd1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign ovf_d = flush ? 1'b0 : (ovf_q | (wr_en && fifo_full && !pop));

  always_ff @(posedge core_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      seq_q   <= 1'b0;
      char_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef CONSOLE_TX_PACE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      char_q  <= char_d;
      ovf_q   <= ovf_d;
`ifdef CONSOLE_TX_PACE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign level_sat  = (32'(fifo_level) > 32'd255) ? 8'hff : 8'(fifo_level);
  assign overflow   = ovf_q;
  assign tx_pending = (state_q == StWaitAck);

  always_comb begin
    tx_word                    = '0;
    tx_word[CHAR_LSB +: 8]     = 8'(char_q);
    tx_word[LEVEL_LSB +: 8]    = level_sat;
    tx_word[OVF_BIT]           = ovf_q;
    tx_word[SEQ_BIT]           = seq_q;
  end

endmodule

// File: tb/tb_fpga_console_tx.sv
// Self-checking bench for fpga_console_tx: directed cases plus randomized traffic vs. a queue model.
module tb_fpga_console_tx;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;

  logic               core_clk = 1'b0;
  logic               rst_b    = 1'b0;
  logic               wr_en    = 1'b0;
  logic [7:0]         wr_data  = '0;
  logic               flush    = 1'b0;
  logic               fw_ack_seq = 1'b0;
  logic [15:0]        pace_div = 16'd10;
  logic               fifo_full, fifo_empty, overflow, tx_pending;
  logic [LEVEL_W-1:0] fifo_level;
  logic [31:0]        tx_word;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic       m_seq, m_ovf, m_pending;
  logic [7:0] m_char;
  int         m_hold;

  fpga_console_tx #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .core_clk   (core_clk),
    .rst_b      (rst_b),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .fw_ack_seq (fw_ack_seq),
    .pace_div   (pace_div),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .tx_word    (tx_word),
    .tx_pending (tx_pending)
  );

  always #5 core_clk = ~core_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    int lvl = m_q.size();
    logic [7:0] sat = (lvl > 255) ? 8'hff : 8'(lvl);
    return {m_seq, m_ovf, 14'b0, sat, m_char};
  endfunction

  task automatic check_all();
    check_eq("tx_word", tx_word, model_word());
    check_eq("tx_pending", 32'(tx_pending), 32'(m_pending));
    check_eq("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    check_eq("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
    check_eq("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_seq = 0; m_ovf = 0; m_pending = 0; m_char = '0; m_hold = 0;
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d, input logic f, input logic a);
    bit was_full = (m_q.size() == DEPTH);
    bit popm = 0;
    if (m_pending) begin
      if (a == m_seq) begin
        m_pending = 0;
`ifdef CONSOLE_TX_PACE_EN
        m_hold = int'(pace_div) + 1;
`endif
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_q.size() > 0 && !f) begin
      popm = 1;
    end
    if (popm) begin
      m_char = m_q.pop_front();
      m_seq = ~m_seq;
      m_pending = 1;
    end
    if (f) begin
      m_q.delete();
      m_ovf = 0;
    end else if (w) begin
      if (!was_full || popm) m_q.push_back(d);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic f, input logic a);
    wr_en = w; wr_data = d; flush = f; fw_ack_seq = a;
    @(posedge core_clk);
    model_edge(w, d, f, a);
    #1;
    check_all();
  endtask

  // Reset asserted away from the clock edge; outputs must clear without an edge.
  task automatic do_reset();
    #2;
    rst_b = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge core_clk);
    #1;
    wr_en = 0; flush = 0; fw_ack_seq = 0;
    rst_b = 1'b1;
  endtask

  initial begin
    logic ack_r;
    @(posedge core_clk);
    #1;
    do_reset();
    check_eq("rst_word", tx_word, 32'h0);
    check_eq("rst_empty", 32'(fifo_empty), 32'd1);

    // Single byte: presented two edges after the push
    step(1, 8'h41, 0, 0);
    step(0, 8'h00, 0, 0);
    check_eq("t1_word", tx_word, 32'h8000_0041);
    check_eq("t1_pending", 32'(tx_pending), 32'd1);
    step(0, 8'h00, 0, 1);
    check_eq("t1_ack_pending", 32'(tx_pending), 32'd0);
    check_eq("t1_ack_empty", 32'(fifo_empty), 32'd1);

    // Three back-to-back bytes
    do_reset();
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    step(1, 8'h63, 0, 0);
    check_eq("t2_first", tx_word, 32'h8000_0261);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    check_eq("t2_second", {tx_word[31], tx_word[7:0]}, {1'b0, 8'h62});
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    check_eq("t2_third", {tx_word[31], tx_word[7:0]}, {1'b1, 8'h63});

    // Overflow: one presented, DEPTH buffered, last push dropped
    do_reset();
    step(1, 8'h55, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 8'($urandom), 0, 0);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_bit30", 32'(tx_word[30]), 32'd1);
    check_eq("ovf_full", 32'(fifo_full), 32'd1);
    check_eq("ovf_level", 32'(fifo_level), DEPTH);

    // Flush with a simultaneous push while 0x55 is pending
    step(1, 8'h99, 1, 0);
    check_eq("fl_level", 32'(fifo_level), 32'd0);
    check_eq("fl_ovf", 32'(overflow), 32'd0);
    check_eq("fl_char", 32'(tx_word[7:0]), 32'h55);
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);
    check_eq("fl_no_new", 32'(tx_pending), 32'd0);
    check_eq("fl_char_kept", 32'(tx_word[7:0]), 32'h55);

    // Reset mid-transfer with 5 buffered bytes
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 8'($urandom), 0, 0);
    check_eq("mr_level", 32'(fifo_level), 32'd5);
    do_reset();
    check_eq("mr_word", tx_word, 32'h0);
    check_eq("mr_pending", 32'(tx_pending), 32'd0);

    // Randomized traffic with a firmware that echoes seq after random delays
    ack_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) ack_r = m_seq;
      step(($urandom_range(1) == 1), 8'($urandom), ($urandom_range(63) == 0), ack_r);
      if ($urandom_range(999) == 0) begin
        do_reset();
        ack_r = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
